// File: rtl/operand_stage_pkg.sv
// Shared widths, ALU op field layout and named op constants for the
// decode/operand-fetch stage and the ALU it feeds.
package operand_stage_pkg;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 2 ** ADDR_W;

  // aluOp = {aInvert, bNegate, op[1:0]}
  localparam int ALUOP_AINV   = 3;
  localparam int ALUOP_BNEG   = 2;
  localparam int ALUOP_OP_HI  = 1;
  localparam int ALUOP_OP_LO  = 0;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

  localparam logic [3:0] ALUOP_SUB = 4'b0100;
  localparam logic [3:0] ALUOP_NOP = 4'b0000;

endpackage

// File: rtl/operand_stage_reg_file_2r1w.sv
// Architectural register file: two async read ports, one sync write port,
// r0 reads as zero, same-cycle write data bypassed onto the read ports.
module reg_file_2r1w
  import operand_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr0_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata0_o = regs_q[raddr0_i];
    if (raddr0_i == '0)                     rdata0_o = '0;
    else if (we_i && (waddr_i == raddr0_i)) rdata0_o = wdata_i;
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == '0)                     rdata1_o = '0;
    else if (we_i && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
  end

endmodule

// File: rtl/operand_stage.sv
// Decode/operand-fetch stage: resolves operands with EX/WB forwarding,
// detects load-use hazards and drives the ID/EX register feeding the ALU.
module operand_stage
  import operand_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              validIn,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] imm,
  input  logic              useImm,
  input  logic [3:0]        aluOpIn,
  input  logic [ADDR_W-1:0] rdIn,
  input  logic              regWriteIn,
  input  logic              exValid,
  input  logic              exRegWrite,
  input  logic              exMemRead,
  input  logic [ADDR_W-1:0] exRd,
  input  logic [DATA_W-1:0] exResult,
  input  logic              wbEn,
  input  logic [ADDR_W-1:0] wbAddr,
  input  logic [DATA_W-1:0] wbData,
  input  logic              stallIn,
  input  logic              flush,
  output logic              hazard,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [3:0]        aluOp,
  output logic [ADDR_W-1:0] rdOut,
  output logic              regWriteOut,
  output logic              validOut
);

  logic [DATA_W-1:0] rf_rs1, rf_rs2;
  logic [DATA_W-1:0] op_a, op_b, rs2_val;
  logic              ex_fwd_ok;

  logic [DATA_W-1:0] a_d, a_q, b_d, b_q;
  logic [3:0]        op_d, op_q;
  logic [ADDR_W-1:0] rd_d, rd_q;
  logic              rw_d, rw_q, v_d, v_q;

  reg_file_2r1w u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wbEn),
    .waddr_i  (wbAddr),
    .wdata_i  (wbData),
    .raddr0_i (rs1),
    .raddr1_i (rs2),
    .rdata0_o (rf_rs1),
    .rdata1_o (rf_rs2)
  );

  // A load in EX has no result yet, so it is never a forwarding source.
  assign ex_fwd_ok = exValid && exRegWrite && !exMemRead;

  always_comb begin
    op_a = rf_rs1;
    if (rs1 == '0)                          op_a = '0;
    else if (ex_fwd_ok && (exRd == rs1))    op_a = exResult;
  end

  always_comb begin
    rs2_val = rf_rs2;
    if (rs2 == '0)                          rs2_val = '0;
    else if (ex_fwd_ok && (exRd == rs2))    rs2_val = exResult;
  end

  assign op_b = useImm ? imm : rs2_val;

  assign hazard = !rst && validIn && exValid && exMemRead && exRegWrite &&
                  (exRd != '0) && ((exRd == rs1) || (!useImm && (exRd == rs2)));

  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    op_d = op_q;
    rd_d = rd_q;
    rw_d = rw_q;
    v_d  = v_q;
    if (flush || (!stallIn && (hazard || !validIn))) begin
      a_d  = '0;
      b_d  = '0;
      op_d = ALUOP_NOP;
      rd_d = '0;
      rw_d = 1'b0;
      v_d  = 1'b0;
    end else if (!stallIn) begin
      a_d  = op_a;
      b_d  = op_b;
      op_d = aluOpIn;
      rd_d = rdIn;
      rw_d = regWriteIn;
      v_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= ALUOP_NOP;
      rd_q <= '0;
      rw_q <= 1'b0;
      v_q  <= 1'b0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      op_q <= op_d;
      rd_q <= rd_d;
      rw_q <= rw_d;
      v_q  <= v_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign aluOp       = op_q;
  assign rdOut       = rd_q;
  assign regWriteOut = rw_q;
  assign validOut    = v_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed plus randomized bench for operand_stage against a register-array
// reference model of the stage's operand and pipeline rules.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst, validIn, useImm, regWriteIn;
  logic [3:0]  rs1, rs2, rdIn, exRd, wbAddr, aluOpIn;
  logic [23:0] imm, exResult, wbData;
  logic        exValid, exRegWrite, exMemRead, wbEn, stallIn, flush;
  logic        hazard, regWriteOut, validOut;
  logic [23:0] A, B;
  logic [3:0]  aluOp, rdOut;

  int checks = 0;
  int failures = 0;

  logic [23:0] mregs [16];
  logic [23:0] mA, mB;
  logic [3:0]  mOp, mRd;
  logic        mRw, mV;
  logic [23:0] savA, savB;
  logic [3:0]  savOp;

  always #5 clk = ~clk;

  operand_stage dut (
    .clk(clk), .rst(rst), .validIn(validIn), .rs1(rs1), .rs2(rs2), .imm(imm),
    .useImm(useImm), .aluOpIn(aluOpIn), .rdIn(rdIn), .regWriteIn(regWriteIn),
    .exValid(exValid), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
    .exRd(exRd), .exResult(exResult), .wbEn(wbEn), .wbAddr(wbAddr),
    .wbData(wbData), .stallIn(stallIn), .flush(flush), .hazard(hazard),
    .A(A), .B(B), .aluOp(aluOp), .rdOut(rdOut), .regWriteOut(regWriteOut),
    .validOut(validOut)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] resolve(input logic [3:0] s);
    if (s == 0) return 24'h0;
    if (exValid && exRegWrite && !exMemRead && exRd == s) return exResult;
    if (wbEn && wbAddr == s) return wbData;
    return mregs[s];
  endfunction

  task automatic idle();
    rst = 0; validIn = 0; rs1 = 0; rs2 = 0; imm = 0; useImm = 0; aluOpIn = 0;
    rdIn = 0; regWriteIn = 0; exValid = 0; exRegWrite = 0; exMemRead = 0;
    exRd = 0; exResult = 0; wbEn = 0; wbAddr = 0; wbData = 0;
    stallIn = 0; flush = 0;
  endtask

  // Inputs are already driven; check hazard, advance model, clock, check outputs.
  task automatic step();
    logic hz;
    logic [23:0] a, b;
    #1;
    hz = !rst && validIn && exValid && exMemRead && exRegWrite && exRd != 0 &&
         (exRd == rs1 || (!useImm && exRd == rs2));
    chk("hazard", {31'b0, hazard}, {31'b0, hz});
    a = resolve(rs1);
    b = useImm ? imm : resolve(rs2);
    if (rst) begin
      for (int i = 0; i < 16; i++) mregs[i] = 0;
      {mA, mB, mOp, mRd, mRw, mV} = '0;
    end else begin
      if (flush || (!stallIn && (hz || !validIn)))
        {mA, mB, mOp, mRd, mRw, mV} = '0;
      else if (!stallIn) begin
        mA = a; mB = b; mOp = aluOpIn; mRd = rdIn; mRw = regWriteIn; mV = 1;
      end
      if (wbEn && wbAddr != 0) mregs[wbAddr] = wbData;
    end
    @(posedge clk);
    #1;
    chk("A", {8'b0, A}, {8'b0, mA});
    chk("B", {8'b0, B}, {8'b0, mB});
    chk("aluOp", {28'b0, aluOp}, {28'b0, mOp});
    chk("rdOut", {28'b0, rdOut}, {28'b0, mRd});
    chk("regWriteOut", {31'b0, regWriteOut}, {31'b0, mRw});
    chk("validOut", {31'b0, validOut}, {31'b0, mV});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mregs[i] = 24'hx;
    idle();
    rst = 1; step();
    chk("rst_valid", {31'b0, validOut}, 0);
    chk("rst_A", {8'b0, A}, 0);

    idle(); wbEn = 1; wbAddr = 3; wbData = 24'h00ABCD; step();
    idle(); validIn = 1; rs1 = 3; rs2 = 0; aluOpIn = 4'b0000; step();
    chk("r3_A", {8'b0, A}, 32'h00ABCD);
    chk("r3_B", {8'b0, B}, 0);
    chk("r3_valid", {31'b0, validOut}, 1);

    idle(); wbEn = 1; wbAddr = 0; wbData = 24'h123456; step();
    idle(); validIn = 1; rs1 = 0; rs2 = 5; wbEn = 1; wbAddr = 5; wbData = 24'h000777; step();
    chk("r0_A", {8'b0, A}, 0);
    chk("bypass_B", {8'b0, B}, 32'h000777);

    idle(); validIn = 1; rs1 = 5; exValid = 1; exRegWrite = 1; exRd = 5;
    exResult = 24'h00FFFF; wbEn = 1; wbAddr = 5; wbData = 24'h000001; step();
    chk("exprio_A", {8'b0, A}, 32'h00FFFF);

    idle(); validIn = 1; regWriteIn = 1; rdIn = 9; rs1 = 1; rs2 = 2;
    exValid = 1; exRegWrite = 1; exMemRead = 1; exRd = 2;
    #1; chk("loaduse_hz", {31'b0, hazard}, 1);
    step();
    chk("loaduse_valid", {31'b0, validOut}, 0);
    chk("loaduse_rw", {31'b0, regWriteOut}, 0);
    useImm = 1; rs1 = 7;
    #1; chk("imm_nohz", {31'b0, hazard}, 0);
    step();

    idle(); validIn = 1; rs1 = 3; rs2 = 5; aluOpIn = 4'b1011; rdIn = 4; regWriteIn = 1; step();
    idle(); validIn = 1; rs1 = 5; rs2 = 3; aluOpIn = 4'b0110; flush = 1; stallIn = 1; step();
    chk("flush_valid", {31'b0, validOut}, 0);
    chk("flush_A", {8'b0, A}, 0);
    idle(); validIn = 1; rs1 = 3; rs2 = 5; aluOpIn = 4'b1011; rdIn = 4; regWriteIn = 1; step();
    savA = mA; savB = mB; savOp = mOp;
    for (int k = 0; k < 3; k++) begin
      idle(); stallIn = 1; validIn = 1; rs1 = 5; rs2 = 0; aluOpIn = 4'(k + 1); step();
      chk("stall_A", {8'b0, A}, {8'b0, savA});
      chk("stall_B", {8'b0, B}, {8'b0, savB});
      chk("stall_op", {28'b0, aluOp}, {28'b0, savOp});
    end

    idle(); validIn = 1; useImm = 1; imm = 24'hFFFFFE; aluOpIn = 4'b0100; rs2 = 3; step();
    chk("imm_B", {8'b0, B}, 32'hFFFFFE);
    chk("imm_op", {28'b0, aluOp}, 32'h4);

    idle(); stallIn = 1; rst = 1; step();
    chk("rst_stall_valid", {31'b0, validOut}, 0);

    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      validIn    = ($urandom_range(0, 9) < 8);
      rs1        = 4'($urandom_range(0, 5));
      rs2        = 4'($urandom_range(0, 5));
      imm        = 24'($urandom);
      useImm     = ($urandom_range(0, 3) == 0);
      aluOpIn    = 4'($urandom);
      rdIn       = 4'($urandom);
      regWriteIn = 1'($urandom);
      exValid    = 1'($urandom);
      exRegWrite = 1'($urandom);
      exMemRead  = ($urandom_range(0, 3) == 0);
      exRd       = 4'($urandom_range(0, 5));
      exResult   = 24'($urandom);
      wbEn       = 1'($urandom);
      wbAddr     = 4'($urandom_range(0, 5));
      wbData     = 24'($urandom);
      stallIn    = ($urandom_range(0, 9) == 0);
      flush      = ($urandom_range(0, 14) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
